// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate-level BIST controller:
// FSM state encoding, LFSR/MISR tap masks and the default stimulus seed.
package gate_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FIN     = 2'd3
    } state_e;

    // Stimulus LFSR feedback taps: bits 23, 22, 21, 16.
    localparam logic [23:0] LFSR_TAPS = 24'hE1_0000;

    // Signature MISR feedback taps: bits 15, 13, 12, 10.
    localparam logic [15:0] MISR_TAPS = 16'hB400;

    localparam logic [23:0] DEF_SEED = 24'h00_0001;

endpackage

// File: rtl/gate_bist_ctrl_if.sv
// Control/data bundle between the BIST controller and its environment.
// start/abort/num_pat/rsp in; pat/sig/busy/done out (slave view).
interface gate_bist_ctrl_if #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 10
);
    logic              start;
    logic              abort;
    logic [15:0]       num_pat;
    logic [IN_W-1:0]   pat;
    logic [OUT_W-1:0]  rsp;
    logic [15:0]       sig;
    logic              busy;
    logic              done;

    modport master (
        output start, abort, num_pat, rsp,
        input  pat, sig, busy, done
    );

    modport slave (
        input  start, abort, num_pat, rsp,
        output pat, sig, busy, done
    );
endinterface

// File: rtl/gate_bist_misr.sv
// One MISR step: shifts the signature with tap feedback, folds in rsp.
// Ports: sig (current), rsp (gate response), nxt (next signature).
module gate_bist_misr
    import gate_bist_pkg::*;
#(
    parameter int OUT_W = 10
) (
    input  logic [15:0]      sig,
    input  logic [OUT_W-1:0] rsp,
    output logic [15:0]      nxt
);
    logic fb;

    assign fb  = ^(sig & MISR_TAPS);
    assign nxt = {sig[14:0], fb} ^ 16'(rsp);
endmodule

// File: rtl/gate_bist_ctrl.sv
// BIST controller: drives LFSR stimulus to a gate model, waits SETTLE
// cycles, compacts the response into a MISR. Ports: clk, rst, bus (slave).
module gate_bist_ctrl
    import gate_bist_pkg::*;
#(
    parameter int              IN_W   = 24,
    parameter int              OUT_W  = 10,
    parameter int              SETTLE = 2,
    parameter logic [IN_W-1:0] SEED   = IN_W'(DEF_SEED)
) (
    input  logic        clk,
    input  logic        rst,
    gate_bist_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_SETTLE  = ST_SETTLE;
    localparam logic [1:0] S_CAPTURE = ST_CAPTURE;
    localparam logic [1:0] S_FIN     = ST_FIN;

    // Settle counter only needs to hold SETTLE-1.
    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WW-1:0]   WRLD  = WW'(SETTLE - 1);
    localparam logic [IN_W-1:0] LTAPS = IN_W'(LFSR_TAPS);

    logic [1:0]      state;
    logic [15:0]     cnt;
    logic [WW-1:0]   wcnt;
    logic [IN_W-1:0] pat_q;
    logic [IN_W-1:0] pat_nxt;
    logic [15:0]     sig_q;
    logic [15:0]     sig_nxt;

    assign pat_nxt = {pat_q[IN_W-2:0], ^(pat_q & LTAPS)};

    gate_bist_misr #(.OUT_W(OUT_W)) u_misr (
        .sig (sig_q),
        .rsp (bus.rsp),
        .nxt (sig_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            wcnt  <= '0;
            pat_q <= '0;
            sig_q <= '0;
        end else if (bus.abort && state != S_IDLE) begin
            // pat/sig deliberately left untouched
            state <= S_IDLE;
        end else begin
            unique case (1'b1)
                (state == S_IDLE): begin
                    if (bus.start) begin
                        pat_q <= SEED;
                        sig_q <= '0;
                        cnt   <= bus.num_pat;
                        wcnt  <= WRLD;
                        state <= (bus.num_pat == 16'd0)
                               ? S_FIN : S_SETTLE;
                    end
                end
                (state == S_SETTLE): begin
                    if (wcnt == '0)
                        state <= S_CAPTURE;
                    else
                        wcnt <= wcnt - 1'b1;
                end
                (state == S_CAPTURE): begin
                    sig_q <= sig_nxt;
                    cnt   <= cnt - 16'd1;
                    if (cnt == 16'd1) begin
                        state <= S_FIN;
                    end else begin
                        pat_q <= pat_nxt;
                        wcnt  <= WRLD;
                        state <= S_SETTLE;
                    end
                end
                (state == S_FIN): begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.pat  = pat_q;
    assign bus.sig  = sig_q;
    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_FIN);
endmodule
